id_ex_fwd_reg: RTL and testbench
================================

// Module: id_ex_fwd_reg
// PURPOSE
//  ID/EX pipeline register with registered forwarding control. Captures decoded operands from ID.
//  Computes the 2-bit selects that drive the EX-stage 32-bit 4:1 operand muxes (A and B) one cycle early.
//  Detects load-use hazards and inserts an EX bubble. Sits between decode and the EX operand muxes.
// PARAMETERS
//  DW  32  data width of operands/immediate
//  RW  5   register-address width
// PORTS
//  clk             in   1    rising-edge clock
//  rst             in   1    asynchronous reset, active-low (0 = reset)
//  stall           in   1    global freeze: hold every register
//  flush           in   1    squash: load bubble into EX
//  id_valid        in   1    ID holds a real instruction
//  id_rs1/id_rs2   in   RW   source register numbers
//  id_use_rs1/2    in   1    instruction actually reads rs1/rs2
//  id_rs1_data     in   DW   register-file value, rs1
//  id_rs2_data     in   DW   register-file value, rs2
//  id_imm          in   DW   extended immediate
//  id_alusrc_b     in   1    operand B = immediate
//  id_rd           in   RW   destination register
//  id_regwrite     in   1    writes rd
//  id_memtoreg     in   1    is a load
//  mem_valid       in   1    EX/MEM stage valid
//  mem_rd          in   RW   EX/MEM destination
//  mem_regwrite    in   1    EX/MEM writes rd
//  ex_valid        out  1    EX valid
//  ex_rs1_data     out  DW   EX copy of rs1 value; mux input I0 for A
//  ex_rs2_data     out  DW   EX copy of rs2 value; mux input I0 for B
//  ex_imm          out  DW   EX copy of immediate; mux input I3 for B
//  ex_rd           out  RW   EX destination
//  ex_regwrite     out  1    EX writes rd
//  ex_memtoreg     out  1    EX is a load
//  ex_fwd_a        out  2    operand-A mux select
//  ex_fwd_b        out  2    operand-B mux select
//  load_use_hazard out  1    combinational; ID must hold
// BEHAVIOUR
//  Reset (rst=0, async): every output register = 0, so ex_valid=0 and ex_fwd_a/b=00.
//  Select encoding:
//   - 00 = register value.
//   - 01 = EX/MEM ALU result.
//   - 10 = MEM/WB writeback data.
//   - 11 = immediate (B only; A never 11).
//  Register file is write-through for the WB write, so no third forwarding level exists.
//  load_use_hazard = id_valid & ex_valid & ex_memtoreg & (ex_rd!=0) &
//   ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
//  Forward match at capture edge. ex_* = producer entering MEM; mem_* = producer entering WB.
//   - hitE(r) = ex_valid & ex_regwrite & ex_rd!=0 & ex_rd==r.
//   - hitM(r) = mem_valid & mem_regwrite & mem_rd!=0 & mem_rd==r.
//   - fwd_a_next = hitE(rs1) ? 01 : hitM(rs1) ? 10 : 00. EX/MEM wins when both hit.
//   - fwd_b_next = id_alusrc_b ? 11 : (same rule on rs2).
//   - Register x0 is never forwarded.
//  Per-edge priority, highest first:
//   1. flush: load bubble. Bubble = valid, regwrite, memtoreg, rd, fwd = 0; data/imm = 0.
//   2. stall: all registers hold, including fwd selects.
//   3. load_use_hazard: load bubble.
//   4. else capture the ID fields and fwd_*_next. ex_valid = id_valid.
//  id_valid=0 captures a bubble with fwd=00.
//  Latency: 1 cycle ID->EX. Selects are valid the same cycle as the data they steer.
//  After a load-use bubble, the load sits in MEM/WB at the consumer's capture. The consumer gets fwd=10.
//  Store-data (rs2) forwarding for MEM is out of scope. ex_rs2_data is the raw register value.
//  Reset mid-operation clears the in-flight EX instruction immediately, without waiting for clk.
// TESTING
//  - Reset: rst=0 mid-cycle with ex_valid=1 -> all outputs 0 before the next edge. Release -> normal capture.
//  - Distance 1: add x5 captured, then sub rs1=x5 -> ex_fwd_a=01. With id_alusrc_b=1 -> ex_fwd_b=11.
//  - Distance 2 and priority:
//    - mem_rd=7 only -> fwd_a=10.
//    - ex_rd=7 and mem_rd=7, both regwrite -> fwd_a=01.
//    - rd=x0 in both -> 00.
//  - Load-use:
//    - lw x3 in EX, then ID add rs2=x3 -> load_use_hazard=1, next ex_valid=0.
//    - Following edge: ex_fwd_b=10, hazard=0.
//    - id_use_rs2=0 -> no hazard.
//  - Stall/flush:
//    - stall=1 for 3 cycles -> all outputs held.
//    - stall=1 with flush=1 -> bubble (flush wins).
//    - stall plus hazard -> hold, not bubble.

Source files
------------

// File: rtl/id_ex_fwd_reg.sv
// ID/EX pipeline register with registered operand-forwarding selects.
// Captures the decoded operands, computes the EX operand-mux selects one
// cycle ahead so they arrive together with the data they steer, and
// inserts an EX bubble on a load-use hazard.
module id_ex_fwd_reg #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_use_rs1,
  input  logic          id_use_rs2,
  input  logic [DW-1:0] id_rs1_data,
  input  logic [DW-1:0] id_rs2_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alusrc_b,
  input  logic [RW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_memtoreg,
  input  logic          mem_valid,
  input  logic [RW-1:0] mem_rd,
  input  logic          mem_regwrite,
  output logic          ex_valid,
  output logic [DW-1:0] ex_rs1_data,
  output logic [DW-1:0] ex_rs2_data,
  output logic [DW-1:0] ex_imm,
  output logic [RW-1:0] ex_rd,
  output logic          ex_regwrite,
  output logic          ex_memtoreg,
  output logic [1:0]    ex_fwd_a,
  output logic [1:0]    ex_fwd_b,
  output logic          load_use_hazard
);

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  logic          r_valid;
  logic [DW-1:0] r_rs1_data;
  logic [DW-1:0] r_rs2_data;
  logic [DW-1:0] r_imm;
  logic [RW-1:0] r_rd;
  logic          r_regwrite;
  logic          r_memtoreg;
  logic [1:0]    r_fwd_a;
  logic [1:0]    r_fwd_b;

  logic          w_hazard;
  logic [1:0]    w_fwd_a_next;
  logic [1:0]    w_fwd_b_next;
  logic          w_load_bubble;
  logic          w_capture;

  // A producer matches a source only if it really writes a non-x0 register.
  function automatic logic prod_hit(input logic v, input logic we,
                                    input logic [RW-1:0] rd,
                                    input logic [RW-1:0] r);
    return v & we & (rd != '0) & (rd == r);
  endfunction

  // Nearest producer wins: the instruction now in EX (entering MEM) beats
  // the one in EX/MEM (entering WB). WB itself is covered by the
  // write-through register file.
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] r,
                                         input logic e_v, input logic e_we,
                                         input logic [RW-1:0] e_rd,
                                         input logic m_v, input logic m_we,
                                         input logic [RW-1:0] m_rd);
    if (prod_hit(e_v, e_we, e_rd, r))      return SEL_EXM;
    else if (prod_hit(m_v, m_we, m_rd, r)) return SEL_MWB;
    else                                   return SEL_REG;
  endfunction

  // Load-use hazard and next-cycle forwarding selects from the ID operands.
  always_comb begin
    w_hazard = id_valid & r_valid & r_memtoreg & (r_rd != '0) &
               ((id_use_rs1 & (r_rd == id_rs1)) |
                (id_use_rs2 & (r_rd == id_rs2)));
    w_fwd_a_next = fwd_sel(id_rs1, r_valid, r_regwrite, r_rd,
                           mem_valid, mem_regwrite, mem_rd);
    w_fwd_b_next = id_alusrc_b ? SEL_IMM :
                   fwd_sel(id_rs2, r_valid, r_regwrite, r_rd,
                           mem_valid, mem_regwrite, mem_rd);
    // flush beats stall; stall beats the hazard; an empty ID slot is a bubble
    w_load_bubble = flush | (~stall & (w_hazard | ~id_valid));
    w_capture     = ~flush & ~stall & ~w_hazard & id_valid;
  end

  // EX stage register: bubble, hold, or capture the ID instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_fwd_a    <= SEL_REG;
      r_fwd_b    <= SEL_REG;
    end else if (w_load_bubble) begin
      r_valid    <= 1'b0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_fwd_a    <= SEL_REG;
      r_fwd_b    <= SEL_REG;
    end else if (w_capture) begin
      r_valid    <= 1'b1;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rd       <= id_rd;
      r_regwrite <= id_regwrite;
      r_memtoreg <= id_memtoreg;
      r_fwd_a    <= w_fwd_a_next;
      r_fwd_b    <= w_fwd_b_next;
    end
  end

  assign ex_valid        = r_valid;
  assign ex_rs1_data     = r_rs1_data;
  assign ex_rs2_data     = r_rs2_data;
  assign ex_imm          = r_imm;
  assign ex_rd           = r_rd;
  assign ex_regwrite     = r_regwrite;
  assign ex_memtoreg     = r_memtoreg;
  assign ex_fwd_a        = r_fwd_a;
  assign ex_fwd_b        = r_fwd_b;
  assign load_use_hazard = w_hazard;

endmodule

// File: tb/tb_id_ex_fwd_reg.sv
// Self-checking bench for id_ex_fwd_reg: directed scenarios plus a
// randomized run against a behavioural model of the EX stage contents.
module tb_id_ex_fwd_reg;
  localparam int DW = 32;
  localparam int RW = 5;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mtr;
    logic [1:0]    fa;
    logic [1:0]    fb;
  } ex_t;

  logic clk = 1'b0;
  logic rst, stall, flush, id_valid, id_use_rs1, id_use_rs2, id_alusrc_b;
  logic id_regwrite, id_memtoreg, mem_valid, mem_regwrite;
  logic [RW-1:0] id_rs1, id_rs2, id_rd, mem_rd;
  logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic ex_valid, ex_regwrite, ex_memtoreg, load_use_hazard;
  logic [DW-1:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic [RW-1:0] ex_rd;
  logic [1:0] ex_fwd_a, ex_fwd_b;

  ex_t dut_s, m;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_fwd_reg #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_alusrc_b(id_alusrc_b),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .ex_valid(ex_valid), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
    .load_use_hazard(load_use_hazard)
  );

  assign dut_s = '{ex_valid, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd,
                   ex_regwrite, ex_memtoreg, ex_fwd_a, ex_fwd_b};

  // ---------------- reference model ----------------
  function automatic logic model_hazard();
    if (!(id_valid && m.v && m.mtr && m.rd != 0)) return 1'b0;
    return (id_use_rs1 && m.rd == id_rs1) || (id_use_rs2 && m.rd == id_rs2);
  endfunction

  // Where does the freshest value of register r come from?
  function automatic logic [1:0] model_src(input logic [RW-1:0] r);
    if (r == 0) return 2'd0;
    if (m.v && m.rw && m.rd == r) return 2'd1;
    if (mem_valid && mem_regwrite && mem_rd == r) return 2'd2;
    return 2'd0;
  endfunction

  function automatic ex_t model_next();
    ex_t n;
    if (flush) return '0;
    if (stall) return m;
    if (model_hazard() || !id_valid) return '0;
    n.v = 1'b1; n.a = id_rs1_data; n.b = id_rs2_data; n.imm = id_imm;
    n.rd = id_rd; n.rw = id_regwrite; n.mtr = id_memtoreg;
    n.fa = model_src(id_rs1);
    n.fb = id_alusrc_b ? 2'd3 : model_src(id_rs2);
    return n;
  endfunction

  task automatic step();
    ex_t n;
    n = model_next();
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_alusrc_b = 0; id_regwrite = 0; id_memtoreg = 0; mem_valid = 0;
    mem_regwrite = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; mem_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
  endtask

  task automatic set_instr(input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                           input logic [RW-1:0] rs2, input logic u1,
                           input logic u2, input logic load,
                           input logic alusrc);
    id_valid = 1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; id_regwrite = 1; id_memtoreg = load;
    id_alusrc_b = alusrc;
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 0; idle_inputs(); m = '0;
    #12;
    n_tests++;
    if (dut_s !== ex_t'(0)) begin
      n_fail++; $display("FAIL reset_state: got %h want 0", dut_s);
    end
    rst = 1;
    step();
  endtask

  task automatic test_dist1();
    set_instr(5, 1, 2, 1, 1, 0, 0);           // add x5
    step();
    set_instr(6, 5, 9, 1, 0, 0, 1);           // sub rs1=x5, B=imm
    step();
    n_tests++;
    if (ex_fwd_a !== 2'b01 || ex_fwd_b !== 2'b11 || dut_s !== m) begin
      n_fail++; $display("FAIL dist1: got fa=%b fb=%b st=%h want fa=01 fb=11 st=%h",
                         ex_fwd_a, ex_fwd_b, dut_s, m);
    end
  endtask

  task automatic test_dist2();
    idle_inputs(); step();                    // empty EX
    mem_valid = 1; mem_regwrite = 1; mem_rd = 7;
    set_instr(8, 7, 0, 1, 0, 0, 0);
    step();
    n_tests++;
    if (ex_fwd_a !== 2'b10 || dut_s !== m) begin
      n_fail++; $display("FAIL dist2_mem: got fa=%b want 10", ex_fwd_a);
    end
    set_instr(7, 1, 1, 1, 1, 0, 0); step();   // add x7 now in EX
    set_instr(9, 7, 0, 1, 0, 0, 0); step();
    n_tests++;
    if (ex_fwd_a !== 2'b01 || dut_s !== m) begin
      n_fail++; $display("FAIL dist2_prio: got fa=%b want 01", ex_fwd_a);
    end
    set_instr(0, 1, 1, 1, 1, 0, 0); step();   // writes x0
    mem_rd = 0;
    set_instr(4, 0, 0, 1, 1, 0, 0); step();
    n_tests++;
    if (ex_fwd_a !== 2'b00 || ex_fwd_b !== 2'b00 || dut_s !== m) begin
      n_fail++; $display("FAIL dist2_x0: got fa=%b fb=%b want 00 00", ex_fwd_a, ex_fwd_b);
    end
    mem_valid = 0; mem_regwrite = 0;
  endtask

  task automatic test_load_use();
    set_instr(3, 1, 2, 1, 1, 1, 0); step();   // lw x3
    set_instr(10, 4, 3, 1, 1, 0, 0);          // add rs2=x3
    #1;
    n_tests++;
    if (load_use_hazard !== 1'b1) begin
      n_fail++; $display("FAIL lu_hazard: got %b want 1", load_use_hazard);
    end
    step();
    n_tests++;
    if (ex_valid !== 1'b0 || dut_s !== m) begin
      n_fail++; $display("FAIL lu_bubble: got valid=%b want 0", ex_valid);
    end
    mem_valid = 1; mem_regwrite = 1; mem_rd = 3;   // load moved on to MEM/WB
    #1;
    n_tests++;
    if (load_use_hazard !== 1'b0) begin
      n_fail++; $display("FAIL lu_clear: got %b want 0", load_use_hazard);
    end
    step();
    n_tests++;
    if (ex_fwd_b !== 2'b10 || ex_valid !== 1'b1 || dut_s !== m) begin
      n_fail++; $display("FAIL lu_fwd: got fb=%b v=%b want 10 1", ex_fwd_b, ex_valid);
    end
    mem_valid = 0; mem_regwrite = 0;
    set_instr(3, 1, 2, 1, 1, 1, 0); step();   // lw x3 again
    set_instr(11, 4, 3, 1, 0, 0, 1);          // rs2=x3 not read
    #1;
    n_tests++;
    if (load_use_hazard !== 1'b0) begin
      n_fail++; $display("FAIL lu_unused_rs2: got %b want 0", load_use_hazard);
    end
    step();
  endtask

  task automatic test_stall_flush();
    ex_t held;
    set_instr(12, 1, 2, 1, 1, 0, 0); step();
    held = m;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_instr(13, 12, 12, 1, 1, 0, 0);
      step();
      n_tests++;
      if (dut_s !== held) begin
        n_fail++; $display("FAIL stall_hold%0d: got %h want %h", i, dut_s, held);
      end
    end
    flush = 1; step();
    n_tests++;
    if (dut_s !== ex_t'(0)) begin
      n_fail++; $display("FAIL stall_flush: got %h want 0", dut_s);
    end
    stall = 0; flush = 0;
    set_instr(3, 1, 2, 1, 1, 1, 0); step();   // lw x3
    held = m;
    set_instr(14, 3, 0, 1, 0, 0, 0);
    stall = 1; step();
    n_tests++;
    if (dut_s !== held || ex_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_hazard: got %h want %h", dut_s, held);
    end
    stall = 0;
  endtask

  task automatic test_reset_mid();
    set_instr(15, 1, 2, 1, 1, 0, 0); step();
    #2 rst = 0;
    #1;
    n_tests++;
    if (dut_s !== ex_t'(0)) begin
      n_fail++; $display("FAIL reset_mid: got %h want 0", dut_s);
    end
    m = '0;
    rst = 1;
    set_instr(16, 1, 2, 1, 1, 0, 0); step();
    n_tests++;
    if (ex_valid !== 1'b1 || dut_s !== m) begin
      n_fail++; $display("FAIL reset_release: got %h want %h", dut_s, m);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      id_valid = ($urandom_range(0, 5) != 0);
      id_rs1 = RW'($urandom_range(0, 7)); id_rs2 = RW'($urandom_range(0, 7));
      id_rd = RW'($urandom_range(0, 7));
      id_use_rs1 = $urandom; id_use_rs2 = $urandom; id_alusrc_b = $urandom;
      id_regwrite = $urandom; id_memtoreg = ($urandom_range(0, 2) == 0);
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      mem_valid = $urandom; mem_regwrite = $urandom;
      mem_rd = RW'($urandom_range(0, 7));
      #1;
      n_tests++;
      if (load_use_hazard !== model_hazard()) begin
        n_fail++; $display("FAIL rand_hazard[%0d]: got %b want %b", i,
                           load_use_hazard, model_hazard());
      end
      step();
      n_tests++;
      if (dut_s !== m) begin
        n_fail++; $display("FAIL rand_state[%0d]: got %h want %h", i, dut_s, m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dist1();
    test_dist2();
    test_load_use();
    test_stall_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
